ysyx_23060201_mem_arb: RTL and testbench

//  Shares the single core memory port between the IFU (instruction fetch) and the LSU (load/store).

---
 rtl/ysyx_23060201_mem_arb.sv | 144 ++++++++++++++
 tb/tb_ysyx_23060201_mem_arb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_mem_arb.sv
// Arbiter that shares one memory port between IFU and LSU, with one transaction outstanding at a time.
// Define ARB_RR_EN for round-robin arbitration; leave it undefined for fixed priority set by LSU_PRIO.
module ysyx_23060201_mem_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LSU_PRIO   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ifu_req_valid,
  output logic                    ifu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   ifu_addr,
  output logic                    ifu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ifu_rsp_data,
  input  logic                    lsu_req_valid,
  output logic                    lsu_req_ready,
  input  logic [ADDR_WIDTH-1:0]   lsu_addr,
  input  logic                    lsu_wen,
  input  logic [DATA_WIDTH-1:0]   lsu_wdata,
  input  logic [DATA_WIDTH/8-1:0] lsu_wmask,
  output logic                    lsu_rsp_valid,
  output logic [DATA_WIDTH-1:0]   lsu_rsp_data,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_wen,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rsp_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t                  state, state_next;
  logic                    owner_lsu;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    wen_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wmask_q;

  logic grant_ifu;
  logic grant_lsu;
  logic tie_lsu;
  logic rsp_hit;

`ifdef ARB_RR_EN
  logic last_lsu;

  // On a tie, whoever was not granted last wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_lsu <= 1'b0;
    end else if (grant_ifu || grant_lsu) begin
      last_lsu <= grant_lsu;
    end
  end

  assign tie_lsu = ~last_lsu;
`else
  assign tie_lsu = (LSU_PRIO != 0);
`endif

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    grant_ifu  = 1'b0;
    grant_lsu  = 1'b0;
    rsp_hit    = 1'b0;
    case (state)
      S_IDLE: begin
        if (lsu_req_valid && (!ifu_req_valid || tie_lsu)) begin
          grant_lsu  = 1'b1;
          state_next = S_REQ;
        end else if (ifu_req_valid) begin
          grant_ifu  = 1'b1;
          state_next = S_REQ;
        end
      end
      S_REQ: begin
        // A response in the accept cycle completes the transaction; without ready it is dropped.
        if (mem_req_ready) begin
          rsp_hit    = mem_rsp_valid;
          state_next = mem_rsp_valid ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          rsp_hit    = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    // Reset silences every handshake in the same cycle, not just from the next edge.
    if (!rst) begin
      grant_ifu  = 1'b0;
      grant_lsu  = 1'b0;
      rsp_hit    = 1'b0;
      state_next = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
    end else begin
      state <= state_next;
      if (grant_ifu || grant_lsu) begin
        owner_lsu <= grant_lsu;
        addr_q    <= grant_lsu ? lsu_addr : ifu_addr;
        wen_q     <= grant_lsu & lsu_wen;
        wdata_q   <= grant_lsu ? lsu_wdata : '0;
        wmask_q   <= grant_lsu ? lsu_wmask : '0;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  assign mem_req_valid = rst && (state == S_REQ);
  assign mem_addr      = rst ? addr_q  : '0;
  assign mem_wen       = rst & wen_q;
  assign mem_wdata     = rst ? wdata_q : '0;
  assign mem_wmask     = rst ? wmask_q : '0;

  assign ifu_rsp_valid = rsp_hit & ~owner_lsu;
  assign lsu_rsp_valid = rsp_hit & owner_lsu;
  assign ifu_rsp_data  = ifu_rsp_valid ? mem_rsp_data : '0;
  // Stores complete with zero data; only loads pass the memory data back.
  assign lsu_rsp_data  = (lsu_rsp_valid && !wen_q) ? mem_rsp_data : '0;

endmodule

// File: tb/tb_ysyx_23060201_mem_arb.sv
// Self-checking bench for ysyx_23060201_mem_arb: directed cases plus randomized transactions
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_ysyx_23060201_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [31:0] ifu_addr, ifu_rsp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rsp_data;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_data;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;
  bit model_last_lsu = 1'b0;
  bit grants[$];

  always #5 clk = ~clk;

  ysyx_23060201_mem_arb dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Arbitration rule: a lone requester wins; ties go by mode.
  function automatic bit pick_lsu(input bit iv, input bit lv);
    if (iv && !lv) return 1'b0;
    if (lv && !iv) return 1'b1;
`ifdef ARB_RR_EN
    return !model_last_lsu;
`else
    return 1'b1;
`endif
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ifu_ready"}, ifu_req_ready, 1'b0);
    check({tag, "_lsu_ready"}, lsu_req_ready, 1'b0);
  endtask

  task automatic check_req(input string tag, input logic [31:0] ea, input logic ew,
                           input logic [31:0] ewd, input logic [3:0] ewm);
    check({tag, "_mem_valid"}, mem_req_valid, 1'b1);
    check({tag, "_mem_addr"}, mem_addr, ea);
    check({tag, "_mem_wen"}, mem_wen, ew);
    check({tag, "_mem_wdata"}, mem_wdata, ewd);
    check({tag, "_mem_wmask"}, mem_wmask, ewm);
  endtask

  task automatic check_no_rsp(input string tag);
    check({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, 1'b0);
    check({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, 1'b0);
  endtask

  task automatic check_rsp(input string tag, input bit g_lsu, input logic ew, input logic [31:0] rd);
    check({tag, "_ifu_rsp_valid"}, ifu_rsp_valid, !g_lsu);
    check({tag, "_lsu_rsp_valid"}, lsu_rsp_valid, g_lsu);
    if (g_lsu) check({tag, "_lsu_rsp_data"}, lsu_rsp_data, ew ? 32'h0 : rd);
    else       check({tag, "_ifu_rsp_data"}, ifu_rsp_data, rd);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    ifu_addr = $urandom; lsu_addr = $urandom; lsu_wen = 1'b1;
    lsu_wdata = $urandom; lsu_wmask = 4'hF;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = $urandom;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_quiet("rst");
      check_no_rsp("rst");
      check("rst_mem_valid", mem_req_valid, 1'b0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_wen", mem_wen, 1'b0);
      advance();
    end
    rst = 1'b1;
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    model_last_lsu = 1'b0;
  endtask

  // One full transaction: accept, dr REQ cycles without ready, ready cycle, then response
  // ds cycles after the ready cycle (ds = 0 means zero-latency response in the ready cycle).
  task automatic txn(input string tag, input bit iv, input bit lv,
                     input logic [31:0] ia, input logic [31:0] la, input bit lw,
                     input logic [31:0] lwd, input logic [3:0] lwm,
                     input int dr, input int ds, input logic [31:0] rd);
    bit          g_lsu;
    logic [31:0] ea, ewd;
    logic        ew;
    logic [3:0]  ewm;
    g_lsu = pick_lsu(iv, lv);
    ifu_req_valid = iv; ifu_addr = ia;
    lsu_req_valid = lv; lsu_addr = la; lsu_wen = lw; lsu_wdata = lwd; lsu_wmask = lwm;
    mem_req_ready = 1'($urandom); mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom;
    @(negedge clk);
    check({tag, "_acc_ifu_ready"}, ifu_req_ready, !g_lsu);
    check({tag, "_acc_lsu_ready"}, lsu_req_ready, g_lsu);
    check({tag, "_acc_mem_valid"}, mem_req_valid, 1'b0);
    check_no_rsp({tag, "_acc"});
    model_last_lsu = g_lsu;
    grants.push_back(g_lsu);
    ea  = g_lsu ? la : ia;
    ew  = g_lsu & lw;
    ewd = g_lsu ? lwd : 32'h0;
    ewm = g_lsu ? lwm : 4'h0;
    advance();
    // The granted requester may now change its fields; the losing one keeps waiting.
    if (g_lsu) begin
      lsu_req_valid = 1'b0; lsu_addr = $urandom; lsu_wen = 1'($urandom);
      lsu_wdata = $urandom; lsu_wmask = 4'($urandom);
    end else begin
      ifu_req_valid = 1'b0; ifu_addr = $urandom;
    end
    for (int i = 0; i < dr; i++) begin
      mem_req_ready = 1'b0; mem_rsp_valid = 1'($urandom); mem_rsp_data = $urandom;
      @(negedge clk);
      check_req({tag, "_hold"}, ea, ew, ewd, ewm);
      check_quiet({tag, "_hold"});
      check_no_rsp({tag, "_hold"});
      advance();
    end
    mem_req_ready = 1'b1; mem_rsp_valid = (ds == 0); mem_rsp_data = rd;
    @(negedge clk);
    check_req({tag, "_rdy"}, ea, ew, ewd, ewm);
    check_quiet({tag, "_rdy"});
    if (ds == 0) check_rsp({tag, "_zl"}, g_lsu, ew, rd);
    else         check_no_rsp({tag, "_rdy"});
    advance();
    for (int i = 1; i < ds; i++) begin
      mem_req_ready = 1'($urandom); mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
      @(negedge clk);
      check({tag, "_wait_mem_valid"}, mem_req_valid, 1'b0);
      check_quiet({tag, "_wait"});
      check_no_rsp({tag, "_wait"});
      advance();
    end
    if (ds > 0) begin
      mem_req_ready = 1'($urandom); mem_rsp_valid = 1'b1; mem_rsp_data = rd;
      @(negedge clk);
      check({tag, "_rsp_mem_valid"}, mem_req_valid, 1'b0);
      check_quiet({tag, "_rsp"});
      check_rsp({tag, "_rsp"}, g_lsu, ew, rd);
      advance();
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  initial begin
    bit   iv, lv;
    int   r;
    logic [3:0] tie_exp;

    rst = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    advance();

    // Reset with both requesters active; first grant after release goes to LSU.
    do_reset(2);
    grants.delete();
    txn("first", 1'b1, 1'b1, 32'h8000_0100, 32'h8000_2000, 1'b0, 32'h0, 4'h0, 0, 1, 32'h1234_5678);
    check("first_grant_lsu", grants[0], 1'b1);

    // IFU fetch: ready at T+1, response at T+3.
    txn("fetch", 1'b1, 1'b0, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 4'h0, 0, 2, 32'h0000_0413);

    // LSU store with memory stalling the request for 3 cycles.
    txn("store", 1'b0, 1'b1, 32'h0, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF, 3, 1, 32'hCAFE_F00D);

    // Four back-to-back ties starting from a fresh reset.
    do_reset(1);
    grants.delete();
    for (int i = 0; i < 4; i++)
      txn($sformatf("tie%0d", i), 1'b1, 1'b1, $urandom, $urandom, 1'($urandom),
          $urandom, 4'($urandom), 0, 1, $urandom);
`ifdef ARB_RR_EN
    tie_exp = 4'b0101;
`else
    tie_exp = 4'b1111;
`endif
    for (int i = 0; i < 4; i++) check($sformatf("tie_grant%0d", i), grants[i], tie_exp[i]);

    // Zero-latency memory, twice back to back.
    txn("zl_a", 1'b1, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h0, 4'h0, 0, 0, 32'h0010_0093);
    txn("zl_b", 1'b0, 1'b1, 32'h0, 32'h8000_0040, 1'b0, 32'h0, 4'h0, 0, 0, 32'h5555_AAAA);

    // Reset during WAIT; the late response must be dropped.
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0008;
    @(negedge clk);
    check("rw_acc_ifu_ready", ifu_req_ready, 1'b1);
    advance();
    ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
    @(negedge clk);
    check("rw_rdy_mem_valid", mem_req_valid, 1'b1);
    advance();
    rst = 1'b0; mem_req_ready = 1'b0;
    @(negedge clk);
    check("rw_rst_mem_valid", mem_req_valid, 1'b0);
    check_no_rsp("rw_rst");
    advance();
    rst = 1'b1; model_last_lsu = 1'b0;
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    check_no_rsp("rw_late");
    check("rw_late_mem_valid", mem_req_valid, 1'b0);
    advance();
    mem_rsp_valid = 1'b0;
    txn("rw_idle", 1'b0, 1'b1, 32'h0, 32'h8000_3000, 1'b0, 32'h0, 4'h0, 0, 1, 32'h0BAD_F00D);

    // Randomized traffic against the model.
    for (int n = 0; n < 40; n++) begin
      r  = $urandom_range(1, 3);
      iv = r[0];
      lv = r[1];
      txn($sformatf("rnd%0d", n), iv, lv, $urandom, $urandom, 1'($urandom), $urandom,
          4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
